// File: rtl/mux_pkg.sv
// Shared definitions for the registered N-way selector stage.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package mux_pkg;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_RR     = 1'b1;

    // Next round-robin start index: step past idx, wrapping at the channel count.
    function automatic int unsigned wrap_inc(int unsigned idx, int unsigned n);
        return (idx == n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/sel_mux_stage_if.sv
// Handshake/bus bundle between upstream sources, the selector stage and its consumer.
// Latency: n/a (wiring only).
// Backpressure: carried by req_ready/in_ready upstream and out_ready downstream.
interface sel_mux_stage_if #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 16
);
    localparam int SEL_W = $clog2(NUM_IN);

    logic                      mode;
    logic [NUM_IN*WIDTH-1:0]   in_data;
    logic [SEL_W-1:0]          sel;
    logic                      req_valid;
    logic                      req_ready;
    logic [NUM_IN-1:0]         in_valid;
    logic [NUM_IN-1:0]         in_ready;
    logic [WIDTH-1:0]          out_data;
    logic [SEL_W-1:0]          out_chan;
    logic                      out_err;
    logic                      out_valid;
    logic                      out_ready;

    // Upstream sources plus downstream consumer, i.e. everything around the stage.
    modport master (
        output mode, in_data, sel, req_valid, in_valid, out_ready,
        input  req_ready, in_ready, out_data, out_chan, out_err, out_valid
    );

    // The selector stage itself.
    modport slave (
        input  mode, in_data, sel, req_valid, in_valid, out_ready,
        output req_ready, in_ready, out_data, out_chan, out_err, out_valid
    );

endinterface

// File: rtl/mux_rr_arb.sv
// Rotating-priority arbiter: grants the first requesting channel at or after the pointer.
// Latency: grant is combinational; pointer moves on the edge where advance is high.
// Backpressure: pointer holds whenever advance is low (no load possible or no request).
module mux_rr_arb
    import mux_pkg::*;
#(
    parameter  int NUM_IN = 16,
    localparam int SEL_W  = $clog2(NUM_IN)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_IN-1:0] req,
    input  logic              advance,
    output logic [NUM_IN-1:0] gnt,
    output logic [SEL_W-1:0]  gnt_idx,
    output logic              any_gnt
);

    logic [SEL_W-1:0] ptr;

    // Scan NUM_IN candidates starting at ptr, wrapping modulo NUM_IN; first hit wins.
    // Only indices below NUM_IN are ever visited, so a non-power-of-two count is safe.
    always_comb begin
        int cand;
        gnt     = '0;
        gnt_idx = '0;
        any_gnt = 1'b0;
        cand    = 0;
        for (int k = 0; k < NUM_IN; k++) begin
            cand = int'(ptr) + k;
            if (cand >= NUM_IN) begin
                cand = cand - NUM_IN;
            end
            if (!any_gnt && req[cand]) begin
                any_gnt   = 1'b1;
                gnt_idx   = SEL_W'(cand);
                gnt[cand] = 1'b1;
            end
        end
    end

    // Pointer moves just past the winner so it gets lowest priority next time.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (advance) begin
            ptr <= SEL_W'(wrap_inc(32'(gnt_idx), NUM_IN));
        end
    end

endmodule

// File: rtl/sel_mux_stage.sv
// N-way selector (directed index or round-robin) feeding a one-deep output register.
// Latency: 1 cycle from acceptance to out_valid.
// Backpressure: accepts only when the output register is empty or draining this cycle.
module sel_mux_stage
    import mux_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    sel_mux_stage_if.slave  bus
);

    localparam int SEL_W = $clog2(NUM_IN);

    logic                 can_load;
    logic                 dir_fire;
    logic                 rr_fire;
    logic                 dir_oor;
    logic [WIDTH-1:0]     dir_data;
    logic [WIDTH-1:0]     rr_data;
    logic [NUM_IN-1:0]    rr_gnt;
    logic [SEL_W-1:0]     rr_idx;
    logic                 rr_any;

    logic                 valid_q;
    logic [WIDTH-1:0]     data_q;
    logic [SEL_W-1:0]     chan_q;
    logic                 err_q;

    assign can_load = !valid_q || bus.out_ready;
    assign dir_fire = (bus.mode == MODE_DIRECT) && bus.req_valid && can_load;
    assign rr_fire  = (bus.mode == MODE_RR) && can_load && rr_any;

    mux_rr_arb #(
        .NUM_IN (NUM_IN)
    ) u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (bus.in_valid),
        .advance (rr_fire),
        .gnt     (rr_gnt),
        .gnt_idx (rr_idx),
        .any_gnt (rr_any)
    );

    // Directed path: decode sel into a channel; an index past the last channel yields zero data.
    always_comb begin
        dir_data = '0;
        dir_oor  = int'(bus.sel) >= NUM_IN;
        for (int i = 0; i < NUM_IN; i++) begin
            if (int'(bus.sel) == i) begin
                dir_data = bus.in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Round-robin path: one-hot grant steers the winning channel through an AND-OR mux.
    always_comb begin
        rr_data = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (rr_gnt[i]) begin
                rr_data = rr_data | bus.in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign bus.req_ready = (bus.mode == MODE_DIRECT) && can_load;
    assign bus.in_ready  = ((bus.mode == MODE_RR) && can_load) ? rr_gnt : '0;

    // Output register: load wins over drain, drain alone clears valid and keeps the payload.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            chan_q  <= '0;
            err_q   <= 1'b0;
        end else if (dir_fire) begin
            valid_q <= 1'b1;
            data_q  <= dir_oor ? '0 : dir_data;
            chan_q  <= bus.sel;
            err_q   <= dir_oor;
        end else if (rr_fire) begin
            valid_q <= 1'b1;
            data_q  <= rr_data;
            chan_q  <= rr_idx;
            err_q   <= 1'b0;
        end else if (bus.out_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign bus.out_valid = valid_q;
    assign bus.out_data  = data_q;
    assign bus.out_chan  = chan_q;
    assign bus.out_err   = err_q;

endmodule
